cnn_conv_pool_engine: RTL

Parametrised fused convolution, ReLU and 2x2 max-pool engine for the CNN accelerator.

- Replaces the fixed 28x28, 3x3, packed-port front end with a configurable image size, kernel size and datapath widths.
- Takes the image as a valid/ready pixel stream and the kernel through a write port.
- Emits pooled features as a valid/ready stream with a last marker.
- Sits between the image source and the dense layer.

---
 rtl/cnn_conv_pool_engine.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_conv_pool_engine.sv
// Fused KxK convolution -> ReLU/shift/saturate -> 2x2 max-pool engine over a buffered frame.
// Define CNN_ENGINE_BIAS_EN to add a per-frame bias input applied before ReLU.
module cnn_conv_pool_engine #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int PIX_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       k_wr_en,
    input  logic [((K*K > 1) ? $clog2(K*K) : 1)-1:0]   k_wr_addr,
    input  logic signed [WGT_W-1:0]                    k_wr_data,
`ifdef CNN_ENGINE_BIAS_EN
    input  logic signed [ACC_W-1:0]                    bias,
`endif
    input  logic                                       start,
    input  logic                                       pix_valid,
    output logic                                       pix_ready,
    input  logic [PIX_W-1:0]                           pix_data,
    output logic                                       feat_valid,
    input  logic                                       feat_ready,
    output logic [OUT_W-1:0]                           feat_data,
    output logic                                       feat_last,
    output logic                                       busy,
    output logic                                       done,
    output logic [2:0]                                 dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; a producer
    // holds data/last stable while valid is high and ready is low, and never withdraws valid.

    localparam int CW     = IMG_W - K + 1;
    localparam int CH     = IMG_H - K + 1;
    localparam int PW     = CW / 2;
    localparam int PH     = CH / 2;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NTAP   = K * K;
    localparam int NCONV  = CW * CH;
    localparam int NPOOL  = PW * PH;
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int TA_W   = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int PA_W   = $clog2(NPIX);
    localparam int FA_W   = $clog2(NCONV);
    localparam int QA_W   = (NPOOL > 1) ? $clog2(NPOOL) : 1;
    localparam int RC_W   = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CONV = 3'd2;
    localparam logic [2:0] S_POOL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [RC_W-1:0]  KM1      = RC_W'(K - 1);
    localparam logic [RC_W-1:0]  CWM1     = RC_W'(CW - 1);
    localparam logic [RC_W-1:0]  CHM1     = RC_W'(CH - 1);
    localparam logic [RC_W-1:0]  PWM1     = RC_W'(PW - 1);
    localparam logic [PA_W-1:0]  NPIX_M1  = PA_W'(NPIX - 1);
    localparam logic [QA_W-1:0]  NPOOL_M1 = QA_W'(NPOOL - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);

    logic signed [WGT_W-1:0] r_wgt   [NTAP];
    logic [PIX_W-1:0]        r_frame [NPIX];
    logic [OUT_W-1:0]        r_fbuf  [NCONV];

    logic [2:0]              r_state;
    logic [PA_W-1:0]         r_pcnt;
    logic [RC_W-1:0]         r_cr, r_cc, r_ki, r_kj;
    logic                    r_mac;
    logic signed [ACC_W-1:0] r_acc;
    logic [FA_W-1:0]         r_fwi;
    logic [RC_W-1:0]         r_pr, r_pc;
    logic [1:0]              r_pq;
    logic [QA_W-1:0]         r_pidx;
    logic [OUT_W-1:0]        r_max;
    logic                    r_fvalid;
    logic [OUT_W-1:0]        r_fdata;
    logic                    r_flast;
`ifdef CNN_ENGINE_BIAS_EN
    logic signed [ACC_W-1:0] r_bias;
`endif

    logic [TA_W-1:0]          w_tidx;
    logic [PA_W-1:0]          w_faddr;
    logic [FA_W-1:0]          w_paddr;
    logic [PIX_W-1:0]         w_pix;
    logic signed [WGT_W-1:0]  w_wgt;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext, w_sum, w_tot_s;
    logic [ACC_W-1:0]         w_tot, w_shr;
    logic [OUT_W-1:0]         w_post, w_fval, w_pmax;
    logic                     w_pix_hs, w_feat_hs, w_last_tap, w_last_conv, w_wgt_we;

    assign w_tidx  = TA_W'(int'(r_ki) * K + int'(r_kj));
    assign w_faddr = PA_W'((int'(r_cr) + int'(r_ki)) * IMG_W + int'(r_cc) + int'(r_kj));
    assign w_paddr = FA_W'((2 * int'(r_pr) + int'(r_pq[1])) * CW + 2 * int'(r_pc) + int'(r_pq[0]));
    assign w_pix   = r_frame[w_faddr];
    assign w_wgt   = r_wgt[w_tidx];

    // Pixel is zero-extended so the product is a full-range signed value before widening.
    assign w_prod     = $signed({1'b0, w_pix}) * w_wgt;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;
`ifdef CNN_ENGINE_BIAS_EN
    assign w_tot_s    = w_sum + r_bias;
`else
    assign w_tot_s    = w_sum;
`endif
    assign w_tot  = w_tot_s;
    assign w_shr  = w_tot[ACC_W-1] ? '0 : (w_tot >> SHIFT);
    assign w_post = (w_shr > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : w_shr[OUT_W-1:0];

    assign w_fval = r_fbuf[w_paddr];
    assign w_pmax = (w_fval > r_max) ? w_fval : r_max;

    assign w_pix_hs    = (r_state == S_LOAD) && pix_valid;
    assign w_feat_hs   = r_fvalid && feat_ready;
    assign w_last_tap  = r_mac && (r_ki == KM1) && (r_kj == KM1);
    assign w_last_conv = (r_cr == CHM1) && (r_cc == CWM1);
    assign w_wgt_we    = (r_state == S_IDLE) && k_wr_en && (int'(k_wr_addr) < NTAP);

    assign pix_ready  = (r_state == S_LOAD);
    assign feat_valid = r_fvalid;
    assign feat_data  = r_fdata;
    assign feat_last  = r_flast;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign dbg_state  = r_state;

    // Storage is deliberately unreset: kernel and buffers survive reset and frame end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_wgt_we)
                r_wgt[k_wr_addr] <= k_wr_data;
            if (w_pix_hs)
                r_frame[r_pcnt] <= pix_data;
            if ((r_state == S_CONV) && w_last_tap)
                r_fbuf[r_fwi] <= w_post;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_cr     <= '0;
            r_cc     <= '0;
            r_ki     <= '0;
            r_kj     <= '0;
            r_mac    <= 1'b0;
            r_acc    <= '0;
            r_fwi    <= '0;
            r_pr     <= '0;
            r_pc     <= '0;
            r_pq     <= '0;
            r_pidx   <= '0;
            r_max    <= '0;
            r_fvalid <= 1'b0;
            r_fdata  <= '0;
            r_flast  <= 1'b0;
`ifdef CNN_ENGINE_BIAS_EN
            r_bias   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_pcnt  <= '0;
`ifdef CNN_ENGINE_BIAS_EN
                        r_bias  <= bias;
`endif
                    end
                end
                S_LOAD: begin
                    if (pix_valid) begin
                        r_pcnt <= r_pcnt + 1'b1;
                        if (r_pcnt == NPIX_M1) begin
                            r_state <= S_CONV;
                            r_cr    <= '0;
                            r_cc    <= '0;
                            r_mac   <= 1'b0;
                            r_fwi   <= '0;
                        end
                    end
                end
                S_CONV: begin
                    // One clear cycle, then K*K MAC cycles; the last MAC writes the feature.
                    if (!r_mac) begin
                        r_acc <= '0;
                        r_mac <= 1'b1;
                        r_ki  <= '0;
                        r_kj  <= '0;
                    end else if (w_last_tap) begin
                        r_mac <= 1'b0;
                        r_fwi <= r_fwi + 1'b1;
                        if (r_cc == CWM1) begin
                            r_cc <= '0;
                            r_cr <= r_cr + 1'b1;
                        end else begin
                            r_cc <= r_cc + 1'b1;
                        end
                        if (w_last_conv) begin
                            r_state  <= S_POOL;
                            r_pr     <= '0;
                            r_pc     <= '0;
                            r_pq     <= '0;
                            r_pidx   <= '0;
                            r_fvalid <= 1'b0;
                        end
                    end else begin
                        r_acc <= w_sum;
                        if (r_kj == KM1) begin
                            r_kj <= '0;
                            r_ki <= r_ki + 1'b1;
                        end else begin
                            r_kj <= r_kj + 1'b1;
                        end
                    end
                end
                S_POOL: begin
                    if (!r_fvalid) begin
                        r_pq  <= r_pq + 1'b1;
                        r_max <= (r_pq == 2'd0) ? w_fval : w_pmax;
                        if (r_pq == 2'd3) begin
                            r_fvalid <= 1'b1;
                            r_fdata  <= w_pmax;
                            r_flast  <= (r_pidx == NPOOL_M1);
                        end
                    end else if (w_feat_hs) begin
                        r_fvalid <= 1'b0;
                        r_flast  <= 1'b0;
                        r_pidx   <= r_pidx + 1'b1;
                        if (r_pc == PWM1) begin
                            r_pc <= '0;
                            r_pr <= r_pr + 1'b1;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                        if (r_pidx == NPOOL_M1)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
